// File: rtl/wt_sched_pkg.sv
// Purpose : shared constants and state encoding for the weight read scheduler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: default geometry (NCOL/ADDR_W/KKM_W/NT_W/LAYERS), FSM state codes,
//           state enum for debug visibility, layer counter wrap helper.
package wt_sched_pkg;

  localparam int NCOL_DEF   = 8;
  localparam int ADDR_W_DEF = 14;
  localparam int KKM_W_DEF  = 9;
  localparam int NT_W_DEF   = 6;
  localparam int LAYERS_DEF = 10;

  // State codes kept as plain constants so older netlists/probes see fixed values.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_RUN   = S_RUN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } wt_state_e;

  // Completed-layer counter: wraps LAYERS-1 -> 0.
  function automatic logic [3:0] layer_next(input logic [3:0] cur, input int layers);
    return (cur == 4'(layers - 1)) ? 4'd0 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/wt_skew_chain.sv
// Purpose : systolic skew register chain; stage i carries column i+1 {vld,addr}.
// Latency : one cycle per stage (column c sees column 0 c cycles later).
// Backpressure: hold=1 freezes every stage; clr=1 empties the chain (wins over hold).
// Ports   : clk_cal/rst_cal clock and sync reset; hold, clr controls;
//           in_vld/in_addr column-0 word; out_vld/out_addr columns 1..NCOL-1.
module wt_skew_chain #(
  parameter int NCOL   = 8,
  parameter int ADDR_W = 14
) (
  input  logic                         clk_cal,
  input  logic                         rst_cal,
  input  logic                         hold,
  input  logic                         clr,
  input  logic                         in_vld,
  input  logic [ADDR_W-1:0]            in_addr,
  output logic [NCOL-2:0]              out_vld,
  output logic [(NCOL-1)*ADDR_W-1:0]   out_addr
);

  logic [ADDR_W-1:0] addr_q [NCOL-1];

  always_ff @(posedge clk_cal) begin
    if (rst_cal || clr) begin
      out_vld <= '0;
      for (int i = 0; i < NCOL-1; i++) addr_q[i] <= '0;
    end else if (!hold) begin
      out_vld[0] <= in_vld;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < NCOL-1; i++) begin
        out_vld[i] <= out_vld[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  for (genvar gi = 0; gi < NCOL-1; gi++) begin : g_pack
    assign out_addr[gi*ADDR_W +: ADDR_W] = addr_q[gi];
  end

endmodule

// File: rtl/weight_rd_sched.sv
// Purpose : per-layer weight-buffer read-address scheduler with systolic column skew.
// Latency : first column-0 word the cycle after start; column c lags column 0 by c cycles.
// Backpressure: stall freezes generator/chain/drain and masks wt_vld; abort flushes to IDLE.
// Ports   : clk_cal, rst_cal (sync, active-high); cfg_base_addr/cfg_kkm/cfg_nt/cfg_grp_stride
//           latched on start; start/stall/abort controls; busy/done/layer_cnt status;
//           wt_addr (column c at [c*ADDR_W +: ADDR_W]) and wt_vld per column.
// Option  : WT_SCHED_PERF_EN adds perf_stall_cnt[15:0] (busy stall cycles, saturating).
module weight_rd_sched
  import wt_sched_pkg::*;
#(
  parameter int NCOL   = NCOL_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int KKM_W  = KKM_W_DEF,
  parameter int NT_W   = NT_W_DEF,
  parameter int LAYERS = LAYERS_DEF
) (
  input  logic                     clk_cal,
  input  logic                     rst_cal,
  input  logic [ADDR_W-1:0]        cfg_base_addr,
  input  logic [KKM_W-1:0]         cfg_kkm,
  input  logic [NT_W-1:0]          cfg_nt,
  input  logic [ADDR_W-1:0]        cfg_grp_stride,
  input  logic                     start,
  input  logic                     stall,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [3:0]               layer_cnt,
  output logic [NCOL*ADDR_W-1:0]   wt_addr,
`ifdef WT_SCHED_PERF_EN
  output logic [15:0]              perf_stall_cnt,
`endif
  output logic [NCOL-1:0]          wt_vld
);

  // Drain runs NCOL-1 cycles, counted 0..NCOL-2.
  localparam int DC_W = (NCOL > 2) ? $clog2(NCOL-1) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(NCOL-2);

  logic [1:0]        state;
  logic [KKM_W-1:0]  kkm_q, k_cnt;
  logic [NT_W-1:0]   nt_q, g_cnt;
  logic [ADDR_W-1:0] stride_q, grp_base, addr0;
  logic              vld0;
  logic [DC_W-1:0]   drain_cnt;
  logic              last_word;

  logic [NCOL-2:0]            ch_vld;
  logic [(NCOL-1)*ADDR_W-1:0] ch_addr;

  // The registered column-0 word is the one currently presented; it is the last
  // one once both counters sit at their final values.
  assign last_word = (k_cnt == kkm_q - KKM_W'(1)) && (g_cnt == nt_q - NT_W'(1));

  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      state     <= S_IDLE;
      kkm_q     <= '0;
      nt_q      <= '0;
      stride_q  <= '0;
      k_cnt     <= '0;
      g_cnt     <= '0;
      grp_base  <= '0;
      addr0     <= '0;
      vld0      <= 1'b0;
      drain_cnt <= '0;
      layer_cnt <= '0;
    end else if (abort) begin
      state <= S_IDLE;
      vld0  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kkm_q     <= cfg_kkm;
            nt_q      <= cfg_nt;
            stride_q  <= cfg_grp_stride;
            k_cnt     <= '0;
            g_cnt     <= '0;
            grp_base  <= cfg_base_addr;
            addr0     <= cfg_base_addr;
            drain_cnt <= '0;
            if (cfg_kkm == '0 || cfg_nt == '0) begin
              // Empty layer: nothing to read, report completion straight away.
              state     <= S_DONE;
              layer_cnt <= layer_next(layer_cnt, LAYERS);
            end else begin
              state <= S_RUN;
              vld0  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (last_word) begin
              vld0      <= 1'b0;
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else if (k_cnt == kkm_q - KKM_W'(1)) begin
              k_cnt    <= '0;
              g_cnt    <= g_cnt + NT_W'(1);
              grp_base <= grp_base + stride_q;
              addr0    <= grp_base + stride_q;
            end else begin
              k_cnt <= k_cnt + KKM_W'(1);
              addr0 <= addr0 + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            if (drain_cnt == DRAIN_LAST) begin
              state     <= S_DONE;
              layer_cnt <= layer_next(layer_cnt, LAYERS);
            end else begin
              drain_cnt <= drain_cnt + DC_W'(1);
            end
          end
        end
        default: state <= S_IDLE;  // S_DONE lasts exactly one cycle, stall or not
      endcase
    end
  end

  wt_skew_chain #(
    .NCOL   (NCOL),
    .ADDR_W (ADDR_W)
  ) u_skew (
    .clk_cal  (clk_cal),
    .rst_cal  (rst_cal),
    .hold     (stall),
    .clr      (abort),
    .in_vld   (vld0),
    .in_addr  (addr0),
    .out_vld  (ch_vld),
    .out_addr (ch_addr)
  );

  // A stalled cycle presents no read; the word stays registered and reappears.
  assign wt_vld  = stall ? '0 : {ch_vld, vld0};
  assign wt_addr = {ch_addr, addr0};
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

`ifdef WT_SCHED_PERF_EN
  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      perf_stall_cnt <= '0;
    end else if (!abort && state == S_IDLE && start) begin
      perf_stall_cnt <= '0;
    end else if (busy && stall && perf_stall_cnt != 16'hFFFF) begin
      perf_stall_cnt <= perf_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_rd_sched.sv
module tb_weight_rd_sched;
  localparam int NCOL   = 8;
  localparam int ADDR_W = 14;
  localparam int KKM_W  = 9;
  localparam int NT_W   = 6;
  localparam int LAYERS = 10;

  logic                   clk_cal = 1'b0;
  logic                   rst_cal = 1'b1;
  logic [ADDR_W-1:0]      cfg_base_addr = '0;
  logic [KKM_W-1:0]       cfg_kkm = '0;
  logic [NT_W-1:0]        cfg_nt = '0;
  logic [ADDR_W-1:0]      cfg_grp_stride = '0;
  logic                   start = 1'b0;
  logic                   stall = 1'b0;
  logic                   abort = 1'b0;
  logic                   busy, done;
  logic [3:0]             layer_cnt;
  logic [NCOL*ADDR_W-1:0] wt_addr;
  logic [NCOL-1:0]        wt_vld;
`ifdef WT_SCHED_PERF_EN
  logic [15:0]            perf_stall_cnt;
`endif

  int checks    = 0;
  int failures  = 0;
  int exp_layer = 0;
  int cyc_g     = 0;

  always #5 clk_cal = ~clk_cal;

  weight_rd_sched dut (
    .clk_cal        (clk_cal),
    .rst_cal        (rst_cal),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_kkm        (cfg_kkm),
    .cfg_nt         (cfg_nt),
    .cfg_grp_stride (cfg_grp_stride),
    .start          (start),
    .stall          (stall),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .layer_cnt      (layer_cnt),
    .wt_addr        (wt_addr),
`ifdef WT_SCHED_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .wt_vld         (wt_vld)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_g, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  128'(busy), 128'(0));
    chk({tag, "_done"},  128'(done), 128'(0));
    chk({tag, "_vld"},   128'(wt_vld), 128'(0));
    chk({tag, "_layer"}, 128'(layer_cnt), 128'(exp_layer));
  endtask

  // One layer: the model lists column-0 words up front; column c shows word
  // (progress - c), where progress counts non-stalled cycles since launch.
  task automatic run_layer(input logic [ADDR_W-1:0] base, input int kkm, input int nt,
                           input logic [ADDR_W-1:0] stride, input int stall_pct,
                           input int stall_at, input int stall_len, input int abort_p,
                           input bit noise);
    logic [ADDR_W-1:0]      words [$];
    logic [NCOL-1:0]        ev;
    logic [NCOL*ADDR_W-1:0] ea, am;
    int n, p, idx, stall_left;
    bit stl, ab, dn, fin, stall_used;
    words = {};
    for (int g = 0; g < nt; g++)
      for (int k = 0; k < kkm; k++)
        words.push_back(ADDR_W'(int'(base) + g * int'(stride) + k));
    n = kkm * nt;

    @(posedge clk_cal); #1;
    cfg_base_addr = base; cfg_kkm = KKM_W'(kkm); cfg_nt = NT_W'(nt);
    cfg_grp_stride = stride; start = 1'b1; stall = 1'b0; abort = 1'b0;
    #3;
    chk_idle("pre");

    p = 0; stall_left = 0; fin = 0; stall_used = 0;
    for (int cyc = 1; !fin; cyc++) begin
      @(posedge clk_cal); #1;
      cyc_g = cyc;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        cfg_base_addr = ADDR_W'($urandom); cfg_kkm = KKM_W'($urandom_range(0, 7));
        cfg_nt = NT_W'($urandom_range(0, 3)); cfg_grp_stride = ADDR_W'($urandom);
      end
      ab = (abort_p >= 0) && (p == abort_p);
      if (p == stall_at && !stall_used) begin
        stall_left = stall_len; stall_used = 1;
      end
      stl = (stall_left > 0) || (int'($urandom_range(0, 99)) < stall_pct);
      if (stall_left > 0) stall_left--;
      stall = stl; abort = ab;
      #3;
      dn = (n == 0) ? (cyc == 1) : (p == n + NCOL - 1);
      if (dn) exp_layer = (exp_layer + 1) % LAYERS;
      ev = '0; ea = '0; am = '0;
      for (int c = 0; c < NCOL; c++) begin
        idx = p - c;
        if (!dn && idx >= 0 && idx < n) begin
          ev[c] = !stl;
          am[c*ADDR_W +: ADDR_W] = '1;
          ea[c*ADDR_W +: ADDR_W] = words[idx];
        end
      end
      chk("run_busy",  128'(busy), 128'(1));
      chk("run_done",  128'(done), 128'(dn));
      chk("run_layer", 128'(layer_cnt), 128'(exp_layer));
      chk("run_vld",   128'(wt_vld), 128'(ev));
      chk("run_addr",  128'(wt_addr & am), 128'(ea));
      if (!stl) p++;
      if (dn || ab) fin = 1;
      if (cyc > 3000) begin
        checks++; failures++;
        $error("FAIL timeout cyc=%0d got=no_done exp=done", cyc);
        fin = 1;
      end
    end

    @(posedge clk_cal); #1;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    #3;
    chk_idle("post");
  endtask

  initial begin
    int kk, nn;
    // Reset values
    repeat (2) @(posedge clk_cal);
    #4;
    chk("rst_addr", 128'(wt_addr), 128'(0));
    chk_idle("rst");
    @(posedge clk_cal); #1 rst_cal = 1'b0;

    // Basic two-group layer
    run_layer(14'h100, 3, 2, 14'h10, 0, -1, 0, -1, 0);
    // Two-cycle stall mid-RUN
    run_layer(14'h100, 3, 2, 14'h10, 0, 3, 2, -1, 0);
    // Address wrap
    run_layer(14'h3FFE, 4, 1, 14'h1, 0, -1, 0, -1, 0);
    // Empty layers
    run_layer(14'h055, 0, 3, 14'h4, 0, -1, 0, -1, 0);
    run_layer(14'h077, 5, 0, 14'h4, 0, -1, 0, -1, 0);
    // Abort during DRAIN (n=4, DRAIN covers progress 4..10)
    run_layer(14'h200, 2, 2, 14'h8, 0, -1, 0, 6, 0);
    // Abort together with stall mid-RUN
    run_layer(14'h300, 4, 2, 14'h20, 0, 2, 3, 3, 0);

    // Reset in the middle of a layer
    @(posedge clk_cal); #1;
    cfg_base_addr = 14'h40; cfg_kkm = 9'd5; cfg_nt = 6'd2; cfg_grp_stride = 14'h8; start = 1'b1;
    @(posedge clk_cal); #1 start = 1'b0;
    repeat (3) @(posedge clk_cal);
    #1 rst_cal = 1'b1;
    @(posedge clk_cal); #3;
    exp_layer = 0;
    chk("mrst_addr", 128'(wt_addr), 128'(0));
    chk_idle("mrst");
    @(posedge clk_cal); #1 rst_cal = 1'b0;

    // Ten back-to-back layers: layer_cnt 1..9 then 0, start/cfg noise while busy
    for (int l = 0; l < LAYERS; l++) begin
      kk = $urandom_range(1, 6); nn = $urandom_range(1, 3);
      run_layer(ADDR_W'($urandom), kk, nn, ADDR_W'($urandom), 20, -1, 0, -1, 1);
    end

    // Random layers with random aborts
    for (int l = 0; l < 6; l++) begin
      kk = $urandom_range(1, 5); nn = $urandom_range(1, 3);
      run_layer(ADDR_W'($urandom), kk, nn, ADDR_W'($urandom), 25, -1, 0,
                $urandom_range(0, kk * nn + NCOL - 2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
